// File: rtl/timer_6801_if.sv
// CPU-side register bus of the 6801 timer: address/qualifier/direction, write data, read data.
interface timer_6801_if;
  logic [15:0] address;
  logic        vma;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  modport master (output address, vma, rw, data_in, input data_out);
  modport slave  (input address, vma, rw, data_in, output data_out);
endinterface

// File: rtl/timer_6801.sv
// 6801-style 16-bit timer: free-running counter, output compare, input capture, two-step flag clears.
// Register reads are combinational; all side effects land on the access edge; hold freezes everything but rst.
module timer_6801 #(
  parameter logic [15:0] BASE = 16'h0008
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         tin,
  timer_6801_if.slave  bus,
  output logic         tout,
  output logic         irq_icf,
  output logic         irq_ocf,
  output logic         irq_tof
);

  logic [15:0] frc, ocr, icr;
  logic [4:0]  ctl;
  logic        icf, ocf, tof;
  logic        arm_icf, arm_ocf, arm_tof;
  logic [7:0]  lo_buf;
  logic        sync1, sync2, tin_q;

  logic [15:0] offs;
  logic [2:0]  off;
  logic        acc, rd, wr, rd_tcsr;
  logic        frc_load, ocr_wr, wrap, match;
  logic        rise, fall, cap;
  logic        clr_icf, clr_ocf, clr_tof;

  assign offs     = bus.address - BASE;
  assign acc      = bus.vma && !hold && (bus.address >= BASE) && (offs <= 16'd6);
  assign off      = offs[2:0];
  assign rd       = acc && bus.rw;
  assign wr       = acc && !bus.rw;
  assign rd_tcsr  = rd && (off == 3'd0);

  // Writing the counter high byte presets it; the data byte is irrelevant.
  assign frc_load = wr && (off == 3'd1);
  assign ocr_wr   = wr && ((off == 3'd3) || (off == 3'd4));
  assign wrap     = (frc == 16'hFFFF) && !frc_load;
  assign match    = (frc == ocr) && !ocr_wr;

  assign rise     = sync2 && !tin_q;
  assign fall     = !sync2 && tin_q;
  assign cap      = ctl[1] ? rise : fall;

  assign clr_icf  = arm_icf && rd && (off == 3'd5);
  assign clr_ocf  = arm_ocf && ocr_wr;
  assign clr_tof  = arm_tof && rd && (off == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      frc     <= 16'h0000;
      ocr     <= 16'hFFFF;
      icr     <= 16'h0000;
      ctl     <= 5'b0;
      icf     <= 1'b0;
      ocf     <= 1'b0;
      tof     <= 1'b0;
      arm_icf <= 1'b0;
      arm_ocf <= 1'b0;
      arm_tof <= 1'b0;
      lo_buf  <= 8'h00;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      tin_q   <= 1'b1;
      tout    <= 1'b0;
    end else if (!hold) begin
      sync1 <= tin;
      sync2 <= sync1;
      tin_q <= sync2;
      frc   <= frc_load ? 16'hFFF8 : frc + 16'd1;
      if (wr && (off == 3'd0)) ctl <= bus.data_in[4:0];
      if (wr && (off == 3'd3)) ocr[15:8] <= bus.data_in;
      if (wr && (off == 3'd4)) ocr[7:0]  <= bus.data_in;
      if (match) tout <= ctl[0];
      if (cap) icr <= frc;
      if (rd && (off == 3'd1)) lo_buf <= frc[7:0];
      // A flag set coinciding with its clear wins, and the arm survives.
      icf     <= cap   || (icf && !clr_icf);
      ocf     <= match || (ocf && !clr_ocf);
      tof     <= wrap  || (tof && !clr_tof);
      arm_icf <= (rd_tcsr && icf) || (arm_icf && !(clr_icf && !cap));
      arm_ocf <= (rd_tcsr && ocf) || (arm_ocf && !(clr_ocf && !match));
      arm_tof <= (rd_tcsr && tof) || (arm_tof && !(clr_tof && !wrap));
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (rd && !rst) begin
      case (off)
        3'd0:    bus.data_out = {icf, ocf, tof, ctl};
        3'd1:    bus.data_out = frc[15:8];
        3'd2:    bus.data_out = lo_buf;
        3'd3:    bus.data_out = ocr[15:8];
        3'd4:    bus.data_out = ocr[7:0];
        3'd5:    bus.data_out = icr[15:8];
        3'd6:    bus.data_out = icr[7:0];
        default: bus.data_out = 8'h00;
      endcase
    end
  end

  assign irq_icf = icf && ctl[4];
  assign irq_ocf = ocf && ctl[3];
  assign irq_tof = tof && ctl[2];

endmodule

// File: tb/tb_timer_6801.sv
// Directed bench for timer_6801: reset, counter latch, compare, overflow clear, capture, hold.
module tb_timer_6801;
  localparam logic [15:0] BASE = 16'h0008;

  logic clk = 1'b0;
  logic rst, hold, tin;
  logic tout, irq_icf, irq_ocf, irq_tof;
  logic [15:0] frc_m;
  logic [7:0]  d, exp_hi, exp_lo;
  int total = 0;
  int bad = 0;

  timer_6801_if bus ();

  timer_6801 #(.BASE(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .tin     (tin),
    .bus     (bus),
    .tout    (tout),
    .irq_icf (irq_icf),
    .irq_ocf (irq_ocf),
    .irq_tof (irq_tof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n edges; the counter model follows the bench's own stimulus.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) frc_m = 16'h0000;
      else if (!hold) begin
        if (bus.vma && !bus.rw && bus.address == BASE + 16'd1) frc_m = 16'hFFF8;
        else frc_m = frc_m + 16'd1;
      end
      #1;
    end
  endtask

  task automatic idle();
    bus.vma = 1'b0; bus.rw = 1'b1; bus.address = 16'h0000; bus.data_in = 8'h00;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] v);
    bus.address = BASE + {13'b0, off}; bus.vma = 1'b1; bus.rw = 1'b1;
    #1 v = bus.data_out;
    tick(1);
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] v;
    rd(off, v);
    chk(tag, {8'h00, v}, {8'h00, exp});
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] v);
    bus.address = BASE + {13'b0, off}; bus.vma = 1'b1; bus.rw = 1'b0; bus.data_in = v;
    tick(1);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(2); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; tin = 1'b1; frc_m = 16'h0000;
    idle();
    // Read attempted while reset is asserted.
    bus.address = BASE; bus.vma = 1'b1; bus.rw = 1'b1;
    #1 chk("rst_dout", {8'h00, bus.data_out}, 16'h0000);
    tick(2);
    chk("rst_irq", {13'b0, irq_icf, irq_ocf, irq_tof}, 16'h0000);
    chk("rst_tout", {15'b0, tout}, 16'h0000);
    idle(); rst = 1'b0;
    #1 chk("idle_dout", {8'h00, bus.data_out}, 16'h0000);

    // Counter latch: 20 clocks, high read latches the low byte.
    tick(20);
    rd_chk("frc_hi", 3'd1, 8'h00);
    rd_chk("frc_lo_buf", 3'd2, 8'h14);
    rd_chk("tcsr_rst", 3'd0, 8'h00);
    rd_chk("ocr_hi_rst", 3'd3, 8'hFF);
    rd_chk("ocr_lo_rst", 3'd4, 8'hFF);
    rd_chk("icr_hi_rst", 3'd5, 8'h00);
    rd_chk("icr_lo_rst", 3'd6, 8'h00);

    // Output compare at 0x0010 with OLVL=1, EOCI=1.
    do_reset();
    wr(3'd0, 8'h09);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h10);
    tick(13);
    rd_chk("tcsr_pre_oc", 3'd0, 8'h09);
    chk("oc_tout", {15'b0, tout}, 16'h0001);
    chk("oc_irq", {15'b0, irq_ocf}, 16'h0001);
    wr(3'd3, 8'h00);
    chk("ocf_unarmed_keep", {15'b0, irq_ocf}, 16'h0001);
    rd_chk("tcsr_ocf", 3'd0, 8'h49);
    wr(3'd0, 8'h09);
    chk("ocf_tcsr_wr_keep", {15'b0, irq_ocf}, 16'h0001);
    wr(3'd3, 8'h00);
    chk("ocf_cleared", {15'b0, irq_ocf}, 16'h0000);
    rd_chk("tcsr_ocf_clr", 3'd0, 8'h09);
    chk("tout_kept", {15'b0, tout}, 16'h0001);

    // Overflow; OCR write on the wrap edge inhibits the FFFF compare.
    do_reset();
    wr(3'd1, 8'hAB);
    tick(7);
    wr(3'd3, 8'hFF);
    rd_chk("tcsr_tof", 3'd0, 8'h20);
    rd_chk("frc_hi_clr", 3'd1, 8'h00);
    rd_chk("tcsr_tof_clr", 3'd0, 8'h00);
    wr(3'd0, 8'h04);
    chk("irq_tof_off", {15'b0, irq_tof}, 16'h0000);
    wr(3'd1, 8'h00);
    tick(8);
    chk("irq_tof_on", {15'b0, irq_tof}, 16'h0001);
    chk("tout_olvl0", {15'b0, tout}, 16'h0000);
    rd_chk("tcsr_tof_ocf", 3'd0, 8'h64);
    wr(3'd1, 8'h00);
    tick(7);
    rd_chk("frc_hi_ffff", 3'd1, 8'hFF);
    chk("tof_set_wins", {15'b0, irq_tof}, 16'h0001);
    rd_chk("frc_hi_rearm", 3'd1, 8'h00);
    chk("tof_arm_kept", {15'b0, irq_tof}, 16'h0000);

    // Input capture on rising edge; falling edges ignored.
    do_reset();
    wr(3'd0, 8'h12);
    tin = 1'b0;
    tick(255);
    chk("fall_ignored", {15'b0, irq_icf}, 16'h0000);
    tin = 1'b1;
    tick(4);
    chk("icf_set", {15'b0, irq_icf}, 16'h0001);
    rd_chk("icr_hi", 3'd5, 8'h01);
    rd(3'd6, d);
    total++;
    assert ((d === 8'h02) || (d === 8'h03)) else begin
      bad++;
      $error("FAIL icr_lo observed=%h expected=02or03", d);
    end
    rd_chk("tcsr_icf", 3'd0, 8'h92);
    rd_chk("icr_hi_clr", 3'd5, 8'h01);
    chk("icf_cleared", {15'b0, irq_icf}, 16'h0000);
    tin = 1'b0;
    tick(4);
    chk("fall_ignored2", {15'b0, irq_icf}, 16'h0000);

    // Hold freezes counter and flags; reads are inert.
    tin = 1'b1;
    tick(4);
    rd_chk("tcsr_icf2", 3'd0, 8'h92);
    hold = 1'b1;
    rd_chk("hold_rd_icr", 3'd5, 8'h00);
    rd_chk("hold_rd_frc", 3'd1, 8'h00);
    tick(3);
    hold = 1'b0;
    chk("hold_icf_kept", {15'b0, irq_icf}, 16'h0001);
    exp_hi = frc_m[15:8];
    exp_lo = frc_m[7:0];
    rd_chk("hold_frc_hi", 3'd1, exp_hi);
    rd_chk("hold_frc_lo", 3'd2, exp_lo);
    rd_chk("icr_clr2", 3'd5, 8'h01);
    chk("icf_cleared2", {15'b0, irq_icf}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_6801.md
TIMER_6801 -- requirements
Module: timer_6801

Interface
REQ-001 Parameter BASE, default 16'h0008, register block base address; aligned to 8, covering BASE+0..BASE+6.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hold  input  1  freeze; while 1, no state updates except rst.
REQ-005 address  input  16  CPU address bus.
REQ-006 vma  input  1  valid memory access qualifier.
REQ-007 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-008 data_in  input  8  CPU write data.
REQ-009 data_out  output  8  read data, combinational from address/vma/rw and register state.
REQ-010 tin  input  1  asynchronous input-capture pin.
REQ-011 tout  output  1  output-compare pin, registered.
REQ-012 irq_icf, irq_ocf, irq_tof  output  1 each  interrupt requests to CPU, level, active-high.

Function
REQ-013 Access (acc) SHALL be vma=1, hold=0 and address within BASE..BASE+6; offset = address-BASE.
REQ-014 Register map SHALL be: 0 TCSR; 1/2 FRC hi/lo; 3/4 OCR hi/lo; 5/6 ICR hi/lo (read-only).
REQ-015 TCSR bits SHALL be [7]ICF [6]OCF [5]TOF [4]EICI [3]EOCI [2]ETOI [1]IEDG [0]OLVL; only bits 4..0 writable.
REQ-016 FRC (16 bit) SHALL increment by 1 every clk with hold=0, wrapping FFFF->0000.
REQ-017 FFFF->0000 wrap SHALL set TOF the same edge.
REQ-018 CPU write to offset 1 SHALL load FRC with 16'hFFF8, ignoring data_in; write to offset 2 SHALL be ignored.
REQ-019 Read of offset 1 SHALL return FRC[15:8] and latch FRC[7:0] into lo_buf; read of offset 2 SHALL return lo_buf.
REQ-020 OCR byte writes SHALL update only the addressed byte; compare SHALL be inhibited on the edge of any OCR write.
REQ-021 When not inhibited and FRC==OCR, OCF SHALL set and tout SHALL take OLVL on that edge.
REQ-022 tin SHALL pass a 2-flop synchronizer then an edge detector; IEDG=0 selects falling, 1 rising.
REQ-023 Selected edge SHALL load ICR with current FRC and set ICF on the same edge.
REQ-024 Flag clear SHALL be two-step: reading TCSR while flag=1 arms that flag's clear bit.
REQ-025 Armed ICF SHALL clear on read of offset 5; armed OCF on write of offset 3 or 4; armed TOF on read of offset 1.
REQ-026 Clear SHALL disarm; writing TCSR SHALL NOT clear flags or arms.
REQ-027 Flag set and clear on the same edge: set SHALL win and arm SHALL remain.
REQ-028 irq_icf=ICF&EICI, irq_ocf=OCF&EOCI, irq_tof=TOF&ETOI, combinational.
REQ-029 data_out SHALL be 8'h00 when not a read access.
REQ-030 While hold=1: FRC, flags, arms, ICR, tout and synchronizer all SHALL hold value; bus side effects suppressed.

Reset
REQ-031 rst=1 SHALL override hold and force: FRC=0000, OCR=FFFF, ICR=0000, TCSR=00, lo_buf=00, arms=0, sync flops=1, tout=0.
REQ-032 Outputs during/after reset: irq_*=0, data_out=00; counting resumes the first edge with rst=0.
REQ-033 Reset mid-access SHALL discard the access with no flag or buffer side effect.

Verification
REQ-034 Release rst, 20 clks, read BASE+1 then BASE+2 -> 8'h00 then 8'h14 (lo latched at hi read).
REQ-035 Write OCR=0010, OLVL=1, EOCI=1 -> at FRC==0010 OCF=1, tout=1, irq_ocf=1; read TCSR, write OCR hi -> OCF=0.
REQ-036 Write FRC hi -> FRC=FFF8; 8 clks later TOF=1; read TCSR then BASE+1 -> TOF=0; set ETOI=1 -> irq_tof follows TOF.
REQ-037 IEDG=1, tin rises at FRC=0x0100 -> ICR=0x0102 or 0x0103 (sync latency), ICF=1; falling edge ignored.
REQ-038 hold=1 for 5 clks mid-count -> FRC unchanged, flags unchanged, reads return 00 side-effect free.
REQ-039 TOF re-sets on the edge of its clearing read of BASE+1 -> TOF=1 remains, arm remains.
